// File: rtl/fu_completion_arbiter_pkg.sv
// Shared types and sizing for the FU completion path.
// The FU wrappers import the same FU_COUNT so both sides agree on the array widths.
package fu_completion_arbiter_pkg;

   localparam int unsigned INST_ID_BITS = 6;
   localparam int unsigned FU_COUNT     = 4;
   localparam int unsigned FIFO_DEPTH   = 4;

   localparam int unsigned FU_IDX_BITS  = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1;
   localparam int unsigned PTR_BITS     = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_BITS     = PTR_BITS + 1;

   typedef logic [FU_IDX_BITS-1:0] fu_idx_t;

   typedef struct packed {
      logic [INST_ID_BITS-1:0] inst_id;
   } compl_t;

   // Modulo-FU_COUNT index; correct even when FU_COUNT is not a power of two.
   function automatic fu_idx_t fu_wrap(input int unsigned idx);
      return fu_idx_t'(idx % FU_COUNT);
   endfunction

endpackage

// File: rtl/fu_completion_arbiter_if.sv
// Completion bus between the FU wrappers, the arbiter and the ROB.
// slave = the arbiter; master = the FU wrappers / ROB environment.
interface fu_completion_arbiter_if;
   import fu_completion_arbiter_pkg::*;

   logic [FU_COUNT-1:0]                   fu_out_valid;
   logic [FU_COUNT-1:0][INST_ID_BITS-1:0] fu_out_inst_id;
   logic [FU_COUNT-1:0]                   fu_stall;
   logic                                  rob_complete_valid;
   logic [INST_ID_BITS-1:0]               rob_complete_inst_id;
   fu_idx_t                               rob_complete_fu;
   logic                                  rob_complete_ready;
   logic                                  overflow_err;

   modport slave (
      input  fu_out_valid,
      input  fu_out_inst_id,
      input  rob_complete_ready,
      output fu_stall,
      output rob_complete_valid,
      output rob_complete_inst_id,
      output rob_complete_fu,
      output overflow_err
   );

   modport master (
      output fu_out_valid,
      output fu_out_inst_id,
      output rob_complete_ready,
      input  fu_stall,
      input  rob_complete_valid,
      input  rob_complete_inst_id,
      input  rob_complete_fu,
      input  overflow_err
   );

endinterface

// File: rtl/fu_completion_arbiter_compl_fifo.sv
// Per-FU synchronous completion FIFO with a registered almost-full flag used as issue stall.
// A push to a full FIFO is only accepted when a pop happens in the same cycle.
module fu_completion_arbiter_compl_fifo
   import fu_completion_arbiter_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   push_i,
   input  compl_t push_data_i,
   input  logic   pop_i,
   output compl_t head_c,
   output logic   empty_c,
   output logic   full_c,
   output logic   almost_full_o
);

   compl_t                mem_q [FIFO_DEPTH];
   logic [PTR_BITS-1:0]   wr_ptr_q;
   logic [PTR_BITS-1:0]   rd_ptr_q;
   logic [CNT_BITS-1:0]   count_q;
   logic [CNT_BITS-1:0]   count_d;
   logic                  almost_full_q;
   logic                  do_push;
   logic                  do_pop;

   assign empty_c       = (count_q == '0);
   assign full_c        = (count_q == CNT_BITS'(FIFO_DEPTH));
   assign do_pop        = pop_i && !empty_c;
   assign do_push       = push_i && (!full_c || do_pop);
   assign head_c        = mem_q[rd_ptr_q];
   assign almost_full_o = almost_full_q;

   always_comb begin
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_BITS'(1);
         2'b01:   count_d = count_q - CNT_BITS'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage is not reset; validity is tracked by count/pointers only.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         almost_full_q <= 1'b0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + PTR_BITS'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_BITS'(1);
         end
         count_q       <= count_d;
         almost_full_q <= (count_d >= CNT_BITS'(FIFO_DEPTH - 1));
      end
   end

endmodule

// File: rtl/fu_completion_arbiter.sv
// Buffers per-FU completion pulses and drains one per cycle to the ROB, round-robin across FUs.
// Output register holds steady under backpressure; overflow_err is sticky until reset.
module fu_completion_arbiter
   import fu_completion_arbiter_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   fu_completion_arbiter_if.slave   cmpl
);

   logic [FU_COUNT-1:0]     fifo_empty;
   logic [FU_COUNT-1:0]     fifo_full;
   logic [FU_COUNT-1:0]     fifo_af;
   logic [FU_COUNT-1:0]     fifo_pop;
   logic [FU_COUNT-1:0]     fifo_drop;
   compl_t                  fifo_head [FU_COUNT];

   fu_idx_t                 rr_q;
   fu_idx_t                 rr_d;
   logic                    valid_q;
   logic                    valid_d;
   logic [INST_ID_BITS-1:0] id_q;
   logic [INST_ID_BITS-1:0] id_d;
   fu_idx_t                 fu_q;
   fu_idx_t                 fu_d;
   logic                    err_q;
   logic                    err_d;

   fu_idx_t                 grant;
   fu_idx_t                 cand;
   logic                    grant_valid;
   logic                    load;

   for (genvar g = 0; g < FU_COUNT; g++) begin : g_fifo
      compl_t push_data;
      assign push_data.inst_id = cmpl.fu_out_inst_id[g];

      fu_completion_arbiter_compl_fifo u_fifo (
         .clk           (clk),
         .rst           (rst),
         .push_i        (cmpl.fu_out_valid[g]),
         .push_data_i   (push_data),
         .pop_i         (fifo_pop[g]),
         .head_c        (fifo_head[g]),
         .empty_c       (fifo_empty[g]),
         .full_c        (fifo_full[g]),
         .almost_full_o (fifo_af[g])
      );

      assign fifo_drop[g] = cmpl.fu_out_valid[g] && fifo_full[g] && !fifo_pop[g];
   end

   // First non-empty FIFO at or after the rr pointer, wrapping.
   always_comb begin
      grant_valid = 1'b0;
      grant       = rr_q;
      cand        = rr_q;
      for (int unsigned k = 0; k < FU_COUNT; k++) begin
         cand = fu_wrap(32'(rr_q) + k);
         if (!grant_valid && !fifo_empty[cand]) begin
            grant_valid = 1'b1;
            grant       = cand;
         end
      end
   end

   assign load = !valid_q || cmpl.rob_complete_ready;

   // Output register load, FIFO pop and rr advance all happen together on a load.
   always_comb begin
      valid_d  = valid_q;
      id_d     = id_q;
      fu_d     = fu_q;
      rr_d     = rr_q;
      fifo_pop = '0;
      err_d    = err_q || (|fifo_drop);
      if (load) begin
         valid_d = grant_valid;
         if (grant_valid) begin
            id_d           = fifo_head[grant].inst_id;
            fu_d           = grant;
            rr_d           = fu_wrap(32'(grant) + 32'd1);
            fifo_pop[grant] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_q    <= '0;
         valid_q <= 1'b0;
         id_q    <= '0;
         fu_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         rr_q    <= rr_d;
         valid_q <= valid_d;
         id_q    <= id_d;
         fu_q    <= fu_d;
         err_q   <= err_d;
      end
   end

   assign cmpl.rob_complete_valid   = valid_q;
   assign cmpl.rob_complete_inst_id = id_q;
   assign cmpl.rob_complete_fu      = fu_q;
   assign cmpl.overflow_err         = err_q;
   assign cmpl.fu_stall             = fifo_af;

endmodule

// File: tb/tb_fu_completion_arbiter.sv
// Directed bench for fu_completion_arbiter: latency, round-robin order, backpressure,
// fill/overflow and mid-drain reset, all against hand-computed expectations.
module tb_fu_completion_arbiter;
   import fu_completion_arbiter_pkg::*;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_miscmp;

   fu_completion_arbiter_if bus ();

   fu_completion_arbiter dut (
      .clk  (clk),
      .rst  (rst),
      .cmpl (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miscmp++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_fu();
      bus.fu_out_valid   = '0;
      bus.fu_out_inst_id = '0;
   endtask

   task automatic push(input int fu, input logic [INST_ID_BITS-1:0] id);
      bus.fu_out_valid[fu]   = 1'b1;
      bus.fu_out_inst_id[fu] = id;
   endtask

   task automatic check_out(input string tag, input logic v, input logic [INST_ID_BITS-1:0] id,
                            input int fu);
      check({tag, "_valid"}, 32'(bus.rob_complete_valid), 32'(v));
      if (v) begin
         check({tag, "_id"}, 32'(bus.rob_complete_inst_id), 32'(id));
         check({tag, "_fu"}, 32'(bus.rob_complete_fu), 32'(fu));
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_fu();
      tick();
      tick();
      rst = 1'b0;
   endtask

   logic [INST_ID_BITS-1:0] t3_id [6];
   int                      t3_fu [6];

   initial begin
      n_vec    = 0;
      n_miscmp = 0;
      rst      = 1'b1;
      clear_fu();
      bus.rob_complete_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      check("rst_valid", 32'(bus.rob_complete_valid), 32'd0);
      check("rst_id",    32'(bus.rob_complete_inst_id), 32'd0);
      check("rst_fu",    32'(bus.rob_complete_fu), 32'd0);
      check("rst_stall", 32'(bus.fu_stall), 32'd0);
      check("rst_err",   32'(bus.overflow_err), 32'd0);

      // 1. Single completion, one-cycle latency
      bus.rob_complete_ready = 1'b1;
      push(2, 6'h15);
      tick();
      check_out("t1_e0", 1'b0, 6'h00, 0);
      clear_fu();
      tick();
      check_out("t1_e1", 1'b1, 6'h15, 2);
      tick();
      check_out("t1_e2", 1'b0, 6'h00, 0);

      // 2. All FUs at once, drained in index order from rr=0
      do_reset();
      bus.rob_complete_ready = 1'b1;
      for (int f = 0; f < 4; f++) push(f, 6'(10 + f));
      tick();
      check_out("t2_e0", 1'b0, 6'h00, 0);
      clear_fu();
      for (int f = 0; f < 4; f++) begin
         tick();
         check_out($sformatf("t2_e%0d", f + 1), 1'b1, 6'(10 + f), f);
      end
      tick();
      check_out("t2_e5", 1'b0, 6'h00, 0);

      // 3. Fairness: FU0 streams, FU3 fires once and is granted next
      do_reset();
      bus.rob_complete_ready = 1'b1;
      t3_id = '{6'h20, 6'h33, 6'h21, 6'h22, 6'h23, 6'h24};
      t3_fu = '{0, 3, 0, 0, 0, 0};
      for (int c = 0; c < 7; c++) begin
         clear_fu();
         if (c <= 4) push(0, 6'(32'h20 + c));
         if (c == 1) push(3, 6'h33);
         tick();
         if (c == 0) check_out("t3_e0", 1'b0, 6'h00, 0);
         else        check_out($sformatf("t3_e%0d", c), 1'b1, t3_id[c-1], t3_fu[c-1]);
      end
      clear_fu();
      tick();
      check_out("t3_e7", 1'b0, 6'h00, 0);

      // 4. Backpressure holds output stable, no pop
      do_reset();
      bus.rob_complete_ready = 1'b0;
      push(1, 6'h07);
      tick();
      check_out("t4_e0", 1'b0, 6'h00, 0);
      clear_fu();
      push(1, 6'h08);
      tick();
      check_out("t4_e1", 1'b1, 6'h07, 1);
      clear_fu();
      for (int c = 0; c < 5; c++) begin
         tick();
         check_out($sformatf("t4_hold%0d", c), 1'b1, 6'h07, 1);
      end
      bus.rob_complete_ready = 1'b1;
      tick();
      check_out("t4_next", 1'b1, 6'h08, 1);
      tick();
      check_out("t4_empty", 1'b0, 6'h00, 0);

      // 5. Fill FU1 behind a stalled output register, then overflow
      do_reset();
      bus.rob_complete_ready = 1'b0;
      push(0, 6'h01);
      tick();
      for (int c = 1; c <= 5; c++) begin
         clear_fu();
         push(1, 6'(32'h10 + c));
         tick();
         if (c == 2) check("t5_stall_cnt2", 32'(bus.fu_stall[1]), 32'd0);
         if (c == 3) check("t5_stall_cnt3", 32'(bus.fu_stall[1]), 32'd1);
         if (c == 4) check("t5_err_full",   32'(bus.overflow_err), 32'd0);
      end
      check("t5_err_drop", 32'(bus.overflow_err), 32'd1);
      check("t5_stall0",   32'(bus.fu_stall[0]), 32'd0);
      check_out("t5_held", 1'b1, 6'h01, 0);
      clear_fu();
      bus.rob_complete_ready = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         tick();
         check_out($sformatf("t5_drain%0d", c), 1'b1, 6'(32'h10 + c), 1);
         if (c == 2) check("t5_stall_drop", 32'(bus.fu_stall[1]), 32'd0);
      end
      tick();
      check_out("t5_drained", 1'b0, 6'h00, 0);
      check("t5_err_sticky", 32'(bus.overflow_err), 32'd1);

      // 6. Reset mid-drain discards buffered entries and clears rr/err
      bus.rob_complete_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         clear_fu();
         push(2, 6'(32'h2A + c));
         tick();
      end
      clear_fu();
      check_out("t6_pre", 1'b1, 6'h2A, 2);
      check("t6_pre_stall", 32'(bus.fu_stall[2]), 32'd1);
      rst = 1'b1;
      tick();
      check("t6_valid", 32'(bus.rob_complete_valid), 32'd0);
      check("t6_stall", 32'(bus.fu_stall), 32'd0);
      check("t6_err",   32'(bus.overflow_err), 32'd0);
      check("t6_id",    32'(bus.rob_complete_inst_id), 32'd0);
      rst = 1'b0;
      bus.rob_complete_ready = 1'b1;
      push(1, 6'h01);
      push(3, 6'h03);
      tick();
      clear_fu();
      tick();
      check_out("t6_rr0", 1'b1, 6'h01, 1);
      tick();
      check_out("t6_rr1", 1'b1, 6'h03, 3);
      tick();
      check_out("t6_flushed", 1'b0, 6'h00, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

endmodule
